// File: rtl/console_link_pkg.sv
// ---------------------------------------------------------------------------
// console_link_pkg
// Shared definitions for the console link block: the arbiter state encoding,
// the tag bit that marks a UART byte as bus or console traffic, and the
// default bus word terminator.
// ---------------------------------------------------------------------------
package console_link_pkg;

    // Arbiter states: IDLE arbitrates round-robin, BUS_LOCK keeps the tx
    // stream owned by the bus until its word ends.
    typedef enum logic {
        IDLE     = 1'b0,
        BUS_LOCK = 1'b1
    } linkState_t;

    // Bit 7 of every UART byte tells the far end which stream it belongs to.
    localparam logic TAG_BUS = 1'b1;
    localparam logic TAG_CON = 1'b0;

    // A bus word ends with this character, which also releases the lock.
    localparam logic [6:0] DEFAULT_NEWLINE = 7'h0a;

endpackage

// File: rtl/console_link_arb.sv
// ---------------------------------------------------------------------------
// console_link_arb
// Decides which source (hexbus encoder or console tx) may load the UART tx
// register this cycle. Round-robin between the two while idle; once a bus
// word has started, the bus owns the link until its terminator.
//
// Optional feature: CONSOLE_LINK_TIMEOUT_EN. When defined, an LGIDLE-bit
// idle timer drops a stale bus lock and hands the next slot to the console.
//
// Ports
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_bus_stb        hexbus encoder has a character
//   i_bus_byte       that character (checked for the terminator)
//   i_console_stb    console tx has a character
//   i_tx_ready       tx register can take a byte this cycle
//   i_tx_busy        UART tx stalled (timeout build only)
//   o_bus_sel        bus is the selected source
//   o_con_sel        console is the selected source
// ---------------------------------------------------------------------------
module console_link_arb
    import console_link_pkg::*;
#(
`ifdef CONSOLE_LINK_TIMEOUT_EN
    parameter int         LGIDLE  = 10,
`endif
    parameter logic [6:0] NEWLINE = DEFAULT_NEWLINE
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_bus_stb,
    input  logic [6:0] i_bus_byte,
    input  logic       i_console_stb,
    input  logic       i_tx_ready,
`ifdef CONSOLE_LINK_TIMEOUT_EN
    input  logic       i_tx_busy,
`endif
    output logic       o_bus_sel,
    output logic       o_con_sel
);

    linkState_t r_state;
    linkState_t w_nextState;
    logic       r_lastBus;
    logic       w_busAccept;
    logic       w_conAccept;
    logic       w_busNewline;
    logic       w_idleBusSel;
    logic       w_timeout;

    assign w_busAccept  = i_bus_stb & i_tx_ready & o_bus_sel;
    assign w_conAccept  = i_console_stb & i_tx_ready & o_con_sel;
    assign w_busNewline = (i_bus_byte == NEWLINE);

    // In IDLE the bus wins unless it was served last and the console is
    // also waiting; that alternation keeps either side from starving.
    assign w_idleBusSel = i_bus_stb & (~r_lastBus | ~i_console_stb);

`ifdef CONSOLE_LINK_TIMEOUT_EN
    logic [LGIDLE-1:0] r_idleTimer;

    // The idle timer only measures genuine bus silence: it restarts on every
    // accepted bus byte and is pinned at zero while the UART itself is
    // stalling, since the bus cannot make progress then anyway.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_idleTimer <= '0;
        else if (r_state != BUS_LOCK || w_busAccept || i_tx_busy)
            r_idleTimer <= '0;
        else
            r_idleTimer <= r_idleTimer + 1'b1;
    end

    assign w_timeout = (r_state == BUS_LOCK) & (&r_idleTimer) & ~w_busAccept;
`else
    assign w_timeout = 1'b0;
`endif

    // State register for the arbiter.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    // A non-terminator bus byte opens a word and locks the link; the
    // terminator (or a stale lock timing out) returns to arbitration.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_busAccept && !w_busNewline)
                    w_nextState = BUS_LOCK;
            end
            BUS_LOCK: begin
                if (w_busAccept && w_busNewline)
                    w_nextState = IDLE;
                else if (w_timeout)
                    w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Source selection per state; the console is shut out during a bus word.
    always_comb begin
        o_bus_sel = 1'b0;
        o_con_sel = 1'b0;
        case (r_state)
            IDLE: begin
                o_bus_sel = w_idleBusSel;
                o_con_sel = i_console_stb & ~w_idleBusSel;
            end
            BUS_LOCK: begin
                o_bus_sel = 1'b1;
            end
            default: begin
                o_bus_sel = 1'b0;
                o_con_sel = 1'b0;
            end
        endcase
    end

    // Remember who was served last for the round-robin. A timeout counts as
    // the bus having had its turn, so a waiting console character goes next.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_lastBus <= 1'b0;
        else if (w_busAccept || w_timeout)
            r_lastBus <= 1'b1;
        else if (w_conAccept)
            r_lastBus <= 1'b0;
    end

endmodule

// File: rtl/console_link.sv
// ---------------------------------------------------------------------------
// console_link
// Serial-side partner of the console peripheral. The rx side splits the
// UART byte stream by its tag bit into hexbus decoder and console
// characters. The tx side merges hexbus encoder output and console tx
// characters into one tagged UART stream through a single holding register.
//
// Optional feature: CONSOLE_LINK_TIMEOUT_EN (bus lock idle timeout, see
// console_link_arb).
//
// Ports
//   i_clk, i_reset                   clock, synchronous active-high reset
//   i_rx_stb, i_rx_byte              UART rx byte (no backpressure)
//   o_rx_bus_stb, o_rx_bus_byte      bus character to hexbus decoder
//   o_console_stb, o_console_data    console character to peripheral
//   i_console_stb, i_console_data    console tx character (held while busy)
//   o_console_busy                   console character not taken this cycle
//   i_bus_stb, i_bus_byte            hexbus encoder character
//   o_bus_busy                       bus character not taken this cycle
//   o_tx_stb, o_tx_byte              tagged UART tx byte
//   i_tx_busy                        UART tx busy
// ---------------------------------------------------------------------------
module console_link
    import console_link_pkg::*;
#(
    parameter int         LGIDLE  = 10,
    parameter logic [6:0] NEWLINE = DEFAULT_NEWLINE
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx_stb,
    input  logic [7:0] i_rx_byte,
    output logic       o_rx_bus_stb,
    output logic [6:0] o_rx_bus_byte,
    output logic       o_console_stb,
    output logic [6:0] o_console_data,
    input  logic       i_console_stb,
    input  logic [6:0] i_console_data,
    output logic       o_console_busy,
    input  logic       i_bus_stb,
    input  logic [6:0] i_bus_byte,
    output logic       o_bus_busy,
    output logic       o_tx_stb,
    output logic [7:0] o_tx_byte,
    input  logic       i_tx_busy
);

    // The idle timer needs at least two bits to count anything useful.
    if (LGIDLE < 2) begin : g_lgidleCheck
        $error("console_link: LGIDLE must be at least 2");
    end

    logic w_txReady;
    logic w_busSel;
    logic w_conSel;
    logic w_busAccept;
    logic w_conAccept;

    // The holding register can take a new byte when empty or when the UART
    // is consuming the current one this very cycle.
    assign w_txReady   = ~o_tx_stb | ~i_tx_busy;
    assign w_busAccept = i_bus_stb & w_busSel & w_txReady;
    assign w_conAccept = i_console_stb & w_conSel & w_txReady;

    // Busy is purely a function of readiness and selection, so a source can
    // hold its strobe and see the answer within the same cycle.
    assign o_bus_busy     = ~(w_txReady & w_busSel);
    assign o_console_busy = ~(w_txReady & w_conSel);

    console_link_arb #(
`ifdef CONSOLE_LINK_TIMEOUT_EN
        .LGIDLE        (LGIDLE),
`endif
        .NEWLINE       (NEWLINE)
    ) u_arb (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_bus_stb     (i_bus_stb),
        .i_bus_byte    (i_bus_byte),
        .i_console_stb (i_console_stb),
        .i_tx_ready    (w_txReady),
`ifdef CONSOLE_LINK_TIMEOUT_EN
        .i_tx_busy     (i_tx_busy),
`endif
        .o_bus_sel     (w_busSel),
        .o_con_sel     (w_conSel)
    );

    // Rx split: one registered stage, routed by the tag bit. Each strobe
    // lasts exactly one cycle per incoming byte since nothing is stored.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rx_bus_stb   <= 1'b0;
            o_rx_bus_byte  <= '0;
            o_console_stb  <= 1'b0;
            o_console_data <= '0;
        end else begin
            o_rx_bus_stb   <= i_rx_stb & i_rx_byte[7];
            o_console_stb  <= i_rx_stb & ~i_rx_byte[7];
            o_rx_bus_byte  <= i_rx_byte[6:0];
            o_console_data <= i_rx_byte[6:0];
        end
    end

    // Tx holding register: load the accepted source with its tag, keep the
    // byte steady while the UART is busy, and go empty once it drains with
    // nothing new to send. Reset drops whatever was pending.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_tx_stb  <= 1'b0;
            o_tx_byte <= '0;
        end else if (w_busAccept) begin
            o_tx_stb  <= 1'b1;
            o_tx_byte <= {TAG_BUS, i_bus_byte};
        end else if (w_conAccept) begin
            o_tx_stb  <= 1'b1;
            o_tx_byte <= {TAG_CON, i_console_data};
        end else if (w_txReady) begin
            o_tx_stb  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_console_link.sv
// ---------------------------------------------------------------------------
// tb_console_link
// Self-checking bench for console_link. Expected tx bytes are queued in
// arrival order when each scenario is set up and compared as the UART side
// consumes them.
// ---------------------------------------------------------------------------
module tb_console_link;

    localparam int         LGIDLE       = 4;
    localparam logic [6:0] NL           = 7'h0a;
    localparam int         CYCLE_BUDGET = 200;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_rx_stb;
    logic [7:0] i_rx_byte;
    logic       o_rx_bus_stb;
    logic [6:0] o_rx_bus_byte;
    logic       o_console_stb;
    logic [6:0] o_console_data;
    logic       i_console_stb;
    logic [6:0] i_console_data;
    logic       o_console_busy;
    logic       i_bus_stb;
    logic [6:0] i_bus_byte;
    logic       o_bus_busy;
    logic       o_tx_stb;
    logic [7:0] o_tx_byte;
    logic       i_tx_busy;

    int         checks     = 0;
    int         failures   = 0;
    int         cycleCount = 0;
    logic [7:0] sbQueue[$];

    console_link #(
        .LGIDLE         (LGIDLE),
        .NEWLINE        (NL)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_rx_stb       (i_rx_stb),
        .i_rx_byte      (i_rx_byte),
        .o_rx_bus_stb   (o_rx_bus_stb),
        .o_rx_bus_byte  (o_rx_bus_byte),
        .o_console_stb  (o_console_stb),
        .o_console_data (o_console_data),
        .i_console_stb  (i_console_stb),
        .i_console_data (i_console_data),
        .o_console_busy (o_console_busy),
        .i_bus_stb      (i_bus_stb),
        .i_bus_byte     (i_bus_byte),
        .o_bus_busy     (o_bus_busy),
        .o_tx_stb       (o_tx_stb),
        .o_tx_byte      (o_tx_byte),
        .i_tx_busy      (i_tx_busy)
    );

    // Free-running clock and a cycle counter used to time acceptances.
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cycleCount <= cycleCount + 1;

    // Absolute backstop so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Consume tx bytes whenever the UART side takes one and compare them
    // against the next queued expectation.
    always @(negedge i_clk) begin
        if (!i_reset && o_tx_stb && !i_tx_busy) begin
            if (sbQueue.size() == 0)
                checkOutput("txUnexpected", {24'd0, o_tx_byte}, 32'h100);
            else
                checkOutput("txByte", {24'd0, o_tx_byte}, {24'd0, sbQueue.pop_front()});
        end
    end

    // Drive one rx byte for exactly one cycle.
    task automatic applyStimulus(input logic [7:0] rxByte);
        i_rx_stb  = 1'b1;
        i_rx_byte = rxByte;
        @(posedge i_clk);
        #1;
        i_rx_stb  = 1'b0;
    endtask

    // Offer one bus character and hold it until accepted.
    task automatic busChar(input logic [6:0] c, output int acceptCycle);
        int waited = 0;
        i_bus_stb  = 1'b1;
        i_bus_byte = c;
        @(negedge i_clk);
        while (o_bus_busy && waited < CYCLE_BUDGET) begin
            @(negedge i_clk);
            waited++;
        end
        if (waited >= CYCLE_BUDGET)
            checkOutput("busAcceptTimeout", {31'd0, o_bus_busy}, 32'd0);
        acceptCycle = cycleCount + 1;
        @(posedge i_clk);
        #1;
        i_bus_stb = 1'b0;
    endtask

    // Offer one console character and hold it until accepted.
    task automatic conChar(input logic [6:0] c, output int acceptCycle);
        int waited = 0;
        i_console_stb  = 1'b1;
        i_console_data = c;
        @(negedge i_clk);
        while (o_console_busy && waited < CYCLE_BUDGET) begin
            @(negedge i_clk);
            waited++;
        end
        if (waited >= CYCLE_BUDGET)
            checkOutput("conAcceptTimeout", {31'd0, o_console_busy}, 32'd0);
        acceptCycle = cycleCount + 1;
        @(posedge i_clk);
        #1;
        i_console_stb = 1'b0;
    endtask

    // Wait for every queued tx byte to come out, bounded.
    task automatic drainScoreboard();
        int waited = 0;
        while (sbQueue.size() != 0 && waited < CYCLE_BUDGET) begin
            @(negedge i_clk);
            waited++;
        end
        checkOutput("sbDrain", sbQueue.size(), 32'd0);
        @(posedge i_clk);
        #1;
    endtask

    task automatic resetDut();
        i_reset        = 1'b1;
        i_rx_stb       = 1'b0;
        i_rx_byte      = '0;
        i_console_stb  = 1'b0;
        i_console_data = '0;
        i_bus_stb      = 1'b0;
        i_bus_byte     = '0;
        i_tx_busy      = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    initial begin
        int tBus;
        int tCon;
        int tDummy;

        $display("[TB] console_link bench start");
        resetDut();

        // Reset state.
        @(negedge i_clk);
        checkOutput("rstTxStb", {31'd0, o_tx_stb}, 32'd0);
        checkOutput("rstTxByte", {24'd0, o_tx_byte}, 32'd0);
        checkOutput("rstRxBusStb", {31'd0, o_rx_bus_stb}, 32'd0);
        checkOutput("rstRxBusByte", {25'd0, o_rx_bus_byte}, 32'd0);
        checkOutput("rstConStb", {31'd0, o_console_stb}, 32'd0);
        checkOutput("rstConData", {25'd0, o_console_data}, 32'd0);
        checkOutput("rstBusBusyNoReq", {31'd0, o_bus_busy}, 32'd1);
        @(posedge i_clk);
        #1;

        // Rx split: 0x8A to the bus decoder, then 0x41 to the console.
        applyStimulus(8'h8A);
        i_rx_stb  = 1'b1;
        i_rx_byte = 8'h41;
        @(negedge i_clk);
        checkOutput("rxBusStb", {31'd0, o_rx_bus_stb}, 32'd1);
        checkOutput("rxBusByte", {25'd0, o_rx_bus_byte}, 32'h0a);
        checkOutput("rxBusNoCon", {31'd0, o_console_stb}, 32'd0);
        @(posedge i_clk);
        #1;
        i_rx_stb = 1'b0;
        @(negedge i_clk);
        checkOutput("rxConStb", {31'd0, o_console_stb}, 32'd1);
        checkOutput("rxConData", {25'd0, o_console_data}, 32'h41);
        checkOutput("rxConNoBus", {31'd0, o_rx_bus_stb}, 32'd0);
        @(negedge i_clk);
        checkOutput("rxBusStbOneCycle", {31'd0, o_rx_bus_stb}, 32'd0);
        checkOutput("rxConStbOneCycle", {31'd0, o_console_stb}, 32'd0);
        @(posedge i_clk);
        #1;

        // Bus word "R1\n" with console 'x' arriving one cycle later.
        resetDut();
        sbQueue.push_back(8'hD2);
        sbQueue.push_back(8'hB1);
        sbQueue.push_back(8'h8A);
        sbQueue.push_back(8'h78);
        fork
            begin
                busChar(7'h52, tDummy);
                busChar(7'h31, tDummy);
                busChar(NL, tDummy);
            end
            begin
                @(posedge i_clk);
                #1;
                conChar(7'h78, tDummy);
            end
        join
        drainScoreboard();

        // last_bus=1 with both sides requesting: console goes first.
        resetDut();
        sbQueue.push_back(8'h8A);
        busChar(NL, tDummy);
        drainScoreboard();
        sbQueue.push_back(8'h78);
        sbQueue.push_back(8'hC1);
        sbQueue.push_back(8'h8A);
        fork
            begin
                busChar(7'h41, tDummy);
                busChar(NL, tDummy);
            end
            conChar(7'h78, tDummy);
        join
        drainScoreboard();

        // UART stall for 5 cycles: held byte stable, both sources busy.
        resetDut();
        sbQueue.push_back(8'h71);
        sbQueue.push_back(8'hC2);
        sbQueue.push_back(8'h8A);
        sbQueue.push_back(8'h72);
        conChar(7'h71, tDummy);
        i_tx_busy      = 1'b1;
        i_bus_stb      = 1'b1;
        i_bus_byte     = 7'h42;
        i_console_stb  = 1'b1;
        i_console_data = 7'h72;
        repeat (5) begin
            @(negedge i_clk);
            checkOutput("stallTxByte", {24'd0, o_tx_byte}, 32'h71);
            checkOutput("stallTxStb", {31'd0, o_tx_stb}, 32'd1);
            checkOutput("stallBusBusy", {31'd0, o_bus_busy}, 32'd1);
            checkOutput("stallConBusy", {31'd0, o_console_busy}, 32'd1);
        end
        @(posedge i_clk);
        #1;
        i_tx_busy = 1'b0;
        fork
            begin
                busChar(7'h42, tDummy);
                busChar(NL, tDummy);
            end
            conChar(7'h72, tDummy);
        join
        drainScoreboard();

        // Bus 'R' then silence with console 'y' waiting.
        resetDut();
`ifdef CONSOLE_LINK_TIMEOUT_EN
        sbQueue.push_back(8'hD2);
        sbQueue.push_back(8'h79);
        fork
            busChar(7'h52, tBus);
            begin
                @(posedge i_clk);
                #1;
                conChar(7'h79, tCon);
            end
        join
        checkOutput("timeoutGapMin", {31'd0, (tCon - tBus) >= 16}, 32'd1);
        checkOutput("timeoutGapMax", {31'd0, (tCon - tBus) <= 17}, 32'd1);
`else
        sbQueue.push_back(8'hD2);
        sbQueue.push_back(8'h8A);
        sbQueue.push_back(8'h79);
        fork
            begin
                busChar(7'h52, tBus);
                repeat (40) @(negedge i_clk);
                checkOutput("lockHoldsConsole", {31'd0, o_console_busy}, 32'd1);
                @(posedge i_clk);
                #1;
                busChar(NL, tDummy);
            end
            begin
                @(posedge i_clk);
                #1;
                conChar(7'h79, tCon);
            end
        join
        checkOutput("lockNoEarlyConsole", {31'd0, (tCon - tBus) > 40}, 32'd1);
`endif
        drainScoreboard();

        // Reset during BUS_LOCK with a byte held in the tx register.
        resetDut();
        sbQueue.push_back(8'h7A);
        busChar(7'h52, tDummy);
        i_tx_busy      = 1'b1;
        i_console_stb  = 1'b1;
        i_console_data = 7'h7a;
        @(negedge i_clk);
        checkOutput("preRstTxStb", {31'd0, o_tx_stb}, 32'd1);
        checkOutput("preRstConBusy", {31'd0, o_console_busy}, 32'd1);
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset   = 1'b0;
        i_tx_busy = 1'b0;
        @(negedge i_clk);
        checkOutput("midRstTxStb", {31'd0, o_tx_stb}, 32'd0);
        checkOutput("midRstTxByte", {24'd0, o_tx_byte}, 32'd0);
        checkOutput("midRstConBusy", {31'd0, o_console_busy}, 32'd0);
        @(posedge i_clk);
        #1;
        i_console_stb = 1'b0;
        drainScoreboard();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
